// File: rtl/clownfish_mem_responder_pkg.sv
// Shared constants and FSM encoding for the clownfish line-memory responder.
package clownfish_mem_responder_pkg;

    localparam int unsigned CF_PADDR_W       = 36;
    localparam int unsigned CF_LINE_BITS     = 512;
    localparam int unsigned CF_LINE_OFF_BITS = 6;
    localparam int unsigned CF_CNT_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } cf_state_e;

endpackage

// File: rtl/clownfish_line_sram.sv
// Single-port line array; the read register doubles as the response data holder
// so that it can be loaded at the accept edge and cleared on completion.
module clownfish_line_sram
    import clownfish_mem_responder_pkg::*;
#(
    parameter int unsigned LINE_BITS   = CF_LINE_BITS,
    parameter int unsigned DEPTH_LINES = 1024,
    localparam int unsigned IDX_W      = $clog2(DEPTH_LINES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic                 clr_i,
    input  logic [IDX_W-1:0]     idx_i,
    input  logic [LINE_BITS-1:0] wdata_i,
    output logic [LINE_BITS-1:0] rdata_o
);

    logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];
    logic [LINE_BITS-1:0] rdata_q;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/clownfish_mem_responder.sv
// Memory-side responder: one outstanding line read/write, answered after a
// fixed latency, backed by an on-chip line array mapped at BASE_ADDR.
module clownfish_mem_responder
    import clownfish_mem_responder_pkg::*;
#(
    parameter int unsigned         PADDR_W     = CF_PADDR_W,
    parameter int unsigned         LINE_BITS   = CF_LINE_BITS,
    parameter int unsigned         DEPTH_LINES = 1024,
    parameter logic [PADDR_W-1:0]  BASE_ADDR   = '0,
    parameter int unsigned         LATENCY     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid_i,
    input  logic [PADDR_W-1:0]   req_addr_i,
    input  logic                 req_we_i,
    input  logic [LINE_BITS-1:0] req_data_i,
    output logic                 req_ready_o,
    output logic                 resp_valid_o,
    output logic [LINE_BITS-1:0] resp_data_o,
    output logic                 resp_error_o,
    input  logic                 resp_ready_i
);

    localparam int unsigned IDX_W   = $clog2(DEPTH_LINES);
    localparam int unsigned LINE_AW = PADDR_W - CF_LINE_OFF_BITS;
    localparam logic [LINE_AW-1:0]  BASE_LINE = BASE_ADDR[PADDR_W-1:CF_LINE_OFF_BITS];
    localparam logic [CF_CNT_W-1:0] CNT_INIT  =
        (LATENCY > 1) ? CF_CNT_W'(LATENCY - 2) : '0;

    cf_state_e           state_q, state_d;
    logic [CF_CNT_W-1:0] cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic                error_q, error_d;

    logic [LINE_AW-1:0]  line_off_c;
    logic                in_range_c;
    logic [IDX_W-1:0]    idx_c;
    logic                sram_we_c;
    logic                sram_re_c;
    logic                sram_clr_c;

    // Window decode on the line address; BASE_ADDR is line aligned.
    assign line_off_c = req_addr_i[PADDR_W-1:CF_LINE_OFF_BITS] - BASE_LINE;
    assign in_range_c = (req_addr_i >= BASE_ADDR) &&
                        (line_off_c < LINE_AW'(DEPTH_LINES));
    assign idx_c      = line_off_c[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        valid_d    = valid_q;
        error_d    = error_q;
        sram_we_c  = 1'b0;
        sram_re_c  = 1'b0;
        sram_clr_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && ready_q) begin
                    ready_d    = 1'b0;
                    error_d    = !in_range_c;
                    sram_we_c  = req_we_i && in_range_c;
                    sram_re_c  = !req_we_i && in_range_c;
                    // Writes and errors answer with zero data.
                    sram_clr_c = !(!req_we_i && in_range_c);
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CF_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d    = ST_IDLE;
                    valid_d    = 1'b0;
                    error_d    = 1'b0;
                    ready_d    = 1'b1;
                    sram_clr_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
                error_d = 1'b0;
            end
        endcase
    end

    clownfish_line_sram #(
        .LINE_BITS   (LINE_BITS),
        .DEPTH_LINES (DEPTH_LINES)
    ) u_sram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (sram_we_c),
        .re_i    (sram_re_c),
        .clr_i   (sram_clr_c),
        .idx_i   (idx_c),
        .wdata_i (req_data_i),
        .rdata_o (resp_data_o)
    );

    assign req_ready_o  = ready_q;
    assign resp_valid_o = valid_q;
    assign resp_error_o = error_q;

endmodule
